// File: rtl/rf_pkg.sv
// Shared defaults and port-count limits for the multi-ported register file.
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_MAX_RD = 4;
  localparam int RF_MAX_WR = 2;
endpackage

// File: rtl/rf_read_port.sv
// One registered read port. Write-first bypass forwards same-cycle write data.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  input  logic [NUM_WR-1:0]        wr_act_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o
);
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_q;

  // Higher-numbered write ports are scanned last so they win the bypass.
  always_comb begin
    rd_data_d = mem_data_i;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_act_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i))
        rd_data_d = wr_data_i[w*DATA_W +: DATA_W];
    end
    if ((ZERO_REG != 0) && (rd_addr_i == '0))
      rd_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i)
        rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file: NUM_WR write ports (last port wins), NUM_RD
// registered read ports with write-first bypass, optional hardwired zero entry.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_WR-1:0] wr_act;
  logic              conflict_d, conflict_q;

  // A write to entry 0 is dropped entirely when it is hardwired, so it can
  // neither update storage, bypass, nor flag a conflict.
  always_comb begin
    wr_act = '0;
    for (int w = 0; w < NUM_WR; w++)
      wr_act[w] = wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*ADDR_W +: ADDR_W] == '0));
  end

  generate
    if (NUM_WR == 2) begin : g_conf
      assign conflict_d = wr_act[0] && wr_act[1] &&
                          (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W]);
    end else begin : g_noconf
      assign conflict_d = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w])
          mem_q[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
      ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rd_en[p]),
        .rd_addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
        .mem_data_i(mem_q[rd_addr[p*ADDR_W +: ADDR_W]]),
        .wr_act_i  (wr_act),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data[p*DATA_W +: DATA_W]),
        .rd_valid_o(rd_valid[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: a driver pushes the expected next-cycle outputs, a monitor
// on the falling edge pops and compares them against the DUT.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_valid;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic          wr_conflict;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(wr_conflict)
  );

  typedef struct {
    logic [1:0]    vld;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          conf;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] ref_d0, ref_d1;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the cycle's writes to the array, then reads see the
  // post-write contents (which is exactly write-first with port 1 winning).
  task automatic cycle(input logic r, input logic [1:0] re, input int ra0, input int ra1,
                       input logic [1:0] we, input int wa0, input int wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1);
    exp_t e;
    rst = r; rd_en = re;
    rd_addr = {ra1[AW-1:0], ra0[AW-1:0]};
    wr_en = we;
    wr_addr = {wa1[AW-1:0], wa0[AW-1:0]};
    wr_data = {wd1, wd0};
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_d0 = '0; ref_d1 = '0;
      e.vld = 2'b00; e.conf = 1'b0;
    end else begin
      e.conf = we[0] && we[1] && (wa0 == wa1) && (wa0 != 0);
      if (we[0] && wa0 != 0) ref_mem[wa0] = wd0;
      if (we[1] && wa1 != 0) ref_mem[wa1] = wd1;
      if (re[0]) ref_d0 = ref_mem[ra0];
      if (re[1]) ref_d1 = ref_mem[ra1];
      e.vld = re;
    end
    e.d0 = ref_d0; e.d1 = ref_d1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_valid", {30'd0, rd_valid}, {30'd0, e.vld});
      chk("rd_data0", rd_data[0 +: DW], e.d0);
      chk("rd_data1", rd_data[DW +: DW], e.d1);
      chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, e.conf});
    end
  end

  initial begin
    int guard;
    cycle(1'b1, 2'b11, 1, 2, 2'b11, 4, 5, 32'h1111, 32'h2222);
    cycle(1'b1, 2'b00, 0, 0, 2'b00, 0, 0, '0, '0);
    idle();
    // reset value read
    cycle(1'b0, 2'b01, 7, 0, 2'b00, 0, 0, '0, '0);
    // write then read on both ports
    cycle(1'b0, 2'b00, 0, 0, 2'b01, 3, 0, 32'hDEADBEEF, '0);
    cycle(1'b0, 2'b11, 3, 3, 2'b00, 0, 0, '0, '0);
    // same-cycle bypass
    cycle(1'b0, 2'b01, 5, 0, 2'b01, 5, 0, 32'h12345678, '0);
    idle();
    // zero register: both ports write 0, no conflict, reads 0
    cycle(1'b0, 2'b11, 0, 0, 2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycle(1'b0, 2'b01, 0, 0, 2'b00, 0, 0, '0, '0);
    // dual-write conflict, port 1 wins, with bypass read on port 1
    cycle(1'b0, 2'b10, 0, 9, 2'b11, 9, 9, 32'hAAAA0000, 32'h0000BBBB);
    cycle(1'b0, 2'b01, 9, 0, 2'b00, 0, 0, '0, '0);
    idle();
    // reset overrides a concurrent write
    cycle(1'b0, 2'b00, 0, 0, 2'b01, 2, 0, 32'h55, '0);
    cycle(1'b1, 2'b11, 2, 2, 2'b01, 2, 0, 32'h66, '0);
    cycle(1'b0, 2'b11, 2, 3, 2'b00, 0, 0, '0, '0);
    idle();

    for (int n = 0; n < 600; n++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      cycle(r, 2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom, $urandom);
    end
    idle();

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
